dist_nxn: RTL and testbench

- Computes the fidelity-style distance between two DIM x DIM complex fixed-point matrices: dist2 = |trace(A^H * B) / DIM|^2, returned as an unsigned fraction.
- Generalises the 2x2 distance unit to any power-of-two DIM, with parametrised data and output widths.
- Streams one element per cycle through a pipelined conjugate-multiply-accumulate.
- Sits between the two matrix stores of the compiler search loop; both stores share the emitted row/col index.

---
 rtl/dist_nxn_if.sv | 35 +++
 rtl/dist_nxn.sv | 139 +++++++++++++
 tb/tb_dist_nxn.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/dist_nxn_if.sv
// Matrix-store port bundle for dist_nxn: shared row/col index out, element pairs and ready flags in.
// Latency: none, pure wiring; element data returns one cycle after the index that selects it.
// Backpressure: none; stores only signal ready when a complete matrix is held.
interface dist_nxn_if #(
  parameter int W     = 19,
  parameter int IDX_W = 1,
  parameter int OUT_W = 16
);
  logic signed [W-1:0] mtx_a_real;
  logic signed [W-1:0] mtx_a_imag;
  logic signed [W-1:0] mtx_b_real;
  logic signed [W-1:0] mtx_b_imag;
  logic [IDX_W-1:0]    mtx_row;
  logic [IDX_W-1:0]    mtx_col;
  logic                mtx_a_ready;
  logic                mtx_b_ready;
  logic [OUT_W-1:0]    dist2;
  logic                finished;

  // Distance unit side: issues indices, consumes elements, produces the result.
  modport master (
    input  mtx_a_real, mtx_a_imag, mtx_b_real, mtx_b_imag,
    input  mtx_a_ready, mtx_b_ready,
    output mtx_row, mtx_col,
    output dist2, finished
  );

  // Store / consumer side.
  modport slave (
    output mtx_a_real, mtx_a_imag, mtx_b_real, mtx_b_imag,
    output mtx_a_ready, mtx_b_ready,
    input  mtx_row, mtx_col,
    input  dist2, finished
  );
endinterface

// File: rtl/dist_nxn.sv
// Fidelity distance |trace(A^H*B)/DIM|^2 of two DIMxDIM complex matrices; DIST_NXN_SAT_EN saturates mag>=1.0.
// Latency: finished rises DIM*DIM+4 edges after the start edge, independent of data.
// Backpressure: none; ready inputs are only looked at in IDLE (start) and DONE (release).
module dist_nxn #(
  parameter int DIM   = 2,
  parameter int W     = 19,
  parameter int FRAC  = 17,
  parameter int OUT_W = 16,
  parameter int IDX_W = 1
) (
  input  logic          clk,
  input  logic          reset,
  dist_nxn_if.master    mtx
);
  localparam int KW = 2 * IDX_W;          // flat row-major index {row,col}
  localparam int PW = 2 * W + 1;          // sum of two exact products
  localparam int AW = 2 * W + 1 + 2 * IDX_W;
  localparam int TW = W + 1;              // scaled trace, FRAC fraction bits
  localparam int MW = 2 * TW + 1;         // squared magnitude, 2*FRAC fraction bits

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SCALE, SQUARE, DONE} state_t;

  state_t               state, state_nxt;
  logic [KW-1:0]        idx;
  logic                 d_vld, p_vld;
  logic signed [PW-1:0] pr_re, pr_im;
  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [TW-1:0] tr_re, tr_im;
  logic signed [MW-1:0] sq_re, sq_im;
  logic [MW-1:0]        mag;
  logic [OUT_W-1:0]     dist_nxt, dist2_q;
  logic                 fin_q;
  logic                 both_rdy, start, last_idx;

  assign both_rdy = mtx.mtx_a_ready && mtx.mtx_b_ready;
  assign start    = (state == IDLE) && both_rdy;
  // Row-major order means the flat index is simply {row,col}.
  assign last_idx = &idx;

  assign mtx.mtx_row  = idx[KW-1:IDX_W];
  assign mtx.mtx_col  = idx[IDX_W-1:0];
  assign mtx.dist2    = dist2_q;
  assign mtx.finished = fin_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: DRAIN waits until the last sample has left the data stage.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (both_rdy) state_nxt = FETCH;
      FETCH:   if (last_idx) state_nxt = DRAIN;
      DRAIN:   if (!d_vld)   state_nxt = SCALE;
      SCALE:   state_nxt = SQUARE;
      SQUARE:  state_nxt = DONE;
      DONE:    if (!both_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Index generator: restart at 0 on start, step through FETCH, hold at the last index.
  always_ff @(posedge clk) begin
    if (reset)                          idx <= '0;
    else if (start)                     idx <= '0;
    else if (state == FETCH && !last_idx) idx <= idx + 1'b1;
  end

  // Valid pipeline tracking element data (one cycle after index) and the product stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_vld <= 1'b0;
      p_vld <= 1'b0;
    end else begin
      d_vld <= (state == FETCH);
      p_vld <= d_vld;
    end
  end

  // Conjugate product conj(a)*b, exact at PW bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pr_re <= '0;
      pr_im <= '0;
    end else if (d_vld) begin
      pr_re <= PW'(mtx.mtx_a_real) * PW'(mtx.mtx_b_real) + PW'(mtx.mtx_a_imag) * PW'(mtx.mtx_b_imag);
      pr_im <= PW'(mtx.mtx_a_real) * PW'(mtx.mtx_b_imag) - PW'(mtx.mtx_a_imag) * PW'(mtx.mtx_b_real);
    end
  end

  // Trace accumulators, cleared on start; sized so N products cannot overflow.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (p_vld) begin
      acc_re <= acc_re + AW'(pr_re);
      acc_im <= acc_im + AW'(pr_im);
    end
  end

  // Divide by DIM and drop the extra product fraction bits (floor).
  always_ff @(posedge clk) begin
    if (reset) begin
      tr_re <= '0;
      tr_im <= '0;
    end else if (state == SCALE) begin
      tr_re <= TW'(acc_re >>> (FRAC + IDX_W));
      tr_im <= TW'(acc_im >>> (FRAC + IDX_W));
    end
  end

  // Squared magnitude and fraction selection, with optional saturation on integer part.
  always_comb begin
    sq_re    = MW'(tr_re) * MW'(tr_re);
    sq_im    = MW'(tr_im) * MW'(tr_im);
    mag      = $unsigned(sq_re + sq_im);
    dist_nxt = OUT_W'(mag >> (2 * FRAC - OUT_W));
`ifdef DIST_NXN_SAT_EN
    if ((mag >> (2 * FRAC)) != '0) dist_nxt = '1;
`endif
  end

  // Result register and level-valid flag; finished drops as DONE releases.
  always_ff @(posedge clk) begin
    if (reset) begin
      dist2_q <= '0;
      fin_q   <= 1'b0;
    end else if (state == SQUARE) begin
      dist2_q <= dist_nxt;
      fin_q   <= 1'b1;
    end else if (state == DONE && !both_rdy) begin
      fin_q   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_dist_nxn.sv
// Directed bench for dist_nxn: DIM=2 and DIM=4 instances with behavioural matrix stores.
// Latency: checks index sequence and the exact finished edge of every run.
// Backpressure: exercises ready hold, ready drop, mid-run ready drop and reset abort.
module tb_dist_nxn;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dist_nxn_if #(.W(19), .IDX_W(1), .OUT_W(16)) if2 ();
  dist_nxn_if #(.W(19), .IDX_W(2), .OUT_W(16)) if4 ();

  dist_nxn #(.DIM(2), .W(19), .FRAC(17), .OUT_W(16), .IDX_W(1)) dut2 (.clk(clk), .reset(reset), .mtx(if2.master));
  dist_nxn #(.DIM(4), .W(19), .FRAC(17), .OUT_W(16), .IDX_W(2)) dut4 (.clk(clk), .reset(reset), .mtx(if4.master));

  localparam logic signed [18:0] ONE  = 19'sh20000;
  localparam logic signed [18:0] HALF = 19'sh10000;
  localparam logic signed [18:0] MONE = -19'sh20000;
`ifdef DIST_NXN_SAT_EN
  localparam logic [15:0] UNITY = 16'hFFFF;
`else
  localparam logic [15:0] UNITY = 16'h0000;
`endif

  logic signed [18:0] a2r[4], a2i[4], b2r[4], b2i[4];
  logic signed [18:0] a4r[16], a4i[16], b4r[16], b4i[16];

  // Behavioural stores: element appears one cycle after its index.
  always_ff @(posedge clk) begin
    if2.mtx_a_real <= a2r[{if2.mtx_row, if2.mtx_col}];
    if2.mtx_a_imag <= a2i[{if2.mtx_row, if2.mtx_col}];
    if2.mtx_b_real <= b2r[{if2.mtx_row, if2.mtx_col}];
    if2.mtx_b_imag <= b2i[{if2.mtx_row, if2.mtx_col}];
    if4.mtx_a_real <= a4r[{if4.mtx_row, if4.mtx_col}];
    if4.mtx_a_imag <= a4i[{if4.mtx_row, if4.mtx_col}];
    if4.mtx_b_real <= b4r[{if4.mtx_row, if4.mtx_col}];
    if4.mtx_b_imag <= b4i[{if4.mtx_row, if4.mtx_col}];
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 4; i++) begin
      a2r[i] = '0; a2i[i] = '0; b2r[i] = '0; b2i[i] = '0;
    end
    for (int i = 0; i < 16; i++) begin
      a4r[i] = '0; a4i[i] = '0; b4r[i] = '0; b4i[i] = '0;
    end
  endtask

  task automatic set_ready(input int dim, input bit a, input bit b);
    if (dim == 2) begin
      if2.mtx_a_ready = a; if2.mtx_b_ready = b;
    end else begin
      if4.mtx_a_ready = a; if4.mtx_b_ready = b;
    end
  endtask

  // Called at a negedge; the next posedge is the start edge c0.
  task automatic run(input int dim, input logic [15:0] exp, input string tag, input bit drop_a);
    int n;
    logic [31:0] row, col, fin, d;
    n = dim * dim;
    set_ready(dim, 1'b1, 1'b1);
    for (int e = 0; e <= n + 4; e++) begin
      @(negedge clk);
      if (dim == 2) begin
        row = 32'(if2.mtx_row); col = 32'(if2.mtx_col); fin = 32'(if2.finished); d = 32'(if2.dist2);
      end else begin
        row = 32'(if4.mtx_row); col = 32'(if4.mtx_col); fin = 32'(if4.finished); d = 32'(if4.dist2);
      end
      if (e < n) begin
        chk($sformatf("%s_row%0d", tag, e), row, e / dim);
        chk($sformatf("%s_col%0d", tag, e), col, e % dim);
      end
      if (e == n + 1) chk($sformatf("%s_rowhold", tag), row, dim - 1);
      if (e == n + 3) chk($sformatf("%s_fin_early", tag), fin, 0);
      if (e == n + 4) begin
        chk($sformatf("%s_fin", tag), fin, 1);
        chk($sformatf("%s_dist2", tag), d, 32'(exp));
      end
      if (drop_a && e == 1) set_ready(dim, 1'b0, 1'b1);
      if (drop_a && e == 3) set_ready(dim, 1'b1, 1'b1);
    end
  endtask

  task automatic leave(input int dim, input string tag);
    set_ready(dim, 1'b0, 1'b0);
    @(negedge clk);
    chk(tag, (dim == 2) ? 32'(if2.finished) : 32'(if4.finished), 0);
  endtask

  initial begin
    reset = 1'b1;
    set_ready(2, 1'b0, 1'b0);
    set_ready(4, 1'b0, 1'b0);
    clear_mats();
    repeat (3) @(negedge clk);
    chk("rst_dist2_2", 32'(if2.dist2), 0);
    chk("rst_fin_2",   32'(if2.finished), 0);
    chk("rst_row_2",   32'(if2.mtx_row), 0);
    chk("rst_col_2",   32'(if2.mtx_col), 0);
    chk("rst_dist2_4", 32'(if4.dist2), 0);
    chk("rst_fin_4",   32'(if4.finished), 0);
    reset = 1'b0;
    @(negedge clk);

    // A = I, B = I: trace/2 = 1.0
    a2r[0] = ONE; a2r[3] = ONE; b2r[0] = ONE; b2r[3] = ONE;
    run(2, UNITY, "ident", 1'b0);

    // Readys held high: result held, no new index sequence.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("hold_fin%0d", i), 32'(if2.finished), 1);
      chk($sformatf("hold_dist%0d", i), 32'(if2.dist2), 32'(UNITY));
      chk($sformatf("hold_row%0d", i), 32'(if2.mtx_row), 1);
      chk($sformatf("hold_col%0d", i), 32'(if2.mtx_col), 1);
    end
    set_ready(2, 1'b1, 1'b0);
    @(negedge clk);
    chk("bdrop_fin", 32'(if2.finished), 0);

    // B = swap: trace 0
    clear_mats();
    a2r[0] = ONE; a2r[3] = ONE; b2r[1] = ONE; b2r[2] = ONE;
    run(2, 16'h0000, "swap", 1'b0);
    leave(2, "swap_leave");

    // B = diag(1, i): (1+i)/2, mag 0.5
    clear_mats();
    a2r[0] = ONE; a2r[3] = ONE; b2r[0] = ONE; b2i[3] = ONE;
    run(2, 16'h8000, "diag1i", 1'b0);
    leave(2, "diag1i_leave");

    // B = diag(-1, 0): trace/2 = -0.5, mag 0.25
    clear_mats();
    a2r[0] = ONE; a2r[3] = ONE; b2r[0] = MONE;
    run(2, 16'h4000, "neg", 1'b0);
    leave(2, "neg_leave");

    // A = diag(i, 1), B = diag(0.5i, 0.5): conj gives 0.5+0.5 = 1, /2 -> mag 0.25
    clear_mats();
    a2i[0] = ONE; a2r[3] = ONE; b2i[0] = HALF; b2r[3] = HALF;
    run(2, 16'h4000, "conj", 1'b0);
    leave(2, "conj_leave");

    // Abort: reset after edge c0+3, then full rerun with A-ready dropped during FETCH.
    clear_mats();
    a2r[0] = ONE; a2r[3] = ONE; b2r[0] = ONE; b2i[3] = ONE;
    set_ready(2, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    set_ready(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_dist2", 32'(if2.dist2), 0);
    chk("abort_fin",   32'(if2.finished), 0);
    chk("abort_row",   32'(if2.mtx_row), 0);
    chk("abort_col",   32'(if2.mtx_col), 0);
    reset = 1'b0;
    @(negedge clk);
    run(2, 16'h8000, "rerun", 1'b1);
    leave(2, "rerun_leave");

    // DIM=4: A = I, B = i*I -> trace/4 = i, mag 1.0
    clear_mats();
    for (int i = 0; i < 4; i++) begin
      a4r[i * 5] = ONE; b4i[i * 5] = ONE;
    end
    run(4, UNITY, "d4_iI", 1'b0);
    leave(4, "d4_iI_leave");

    // DIM=4: A = I, B = diag(1,0,0,0) -> 0.25, mag 1/16
    clear_mats();
    for (int i = 0; i < 4; i++) a4r[i * 5] = ONE;
    b4r[0] = ONE;
    run(4, 16'h1000, "d4_e00", 1'b0);
    leave(4, "d4_e00_leave");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
